pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register that replaces the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload bus between two stages using a valid/ready handshake.
- Supports stall (back-pressure), flush (bubble insertion on branch/jump) and an optional 2-entry skid mode that registers in_ready.
- Sits between adjacent stages of the pipelined datapath; the control unit drives flush and the hazard unit drives back-pressure.

Parameters:
- DATA_W, 32, payload width in bits (stage-specific bundle of control fields plus operands).
- SKID, 1, 0 = single register with combinational in_ready; 1 = main + skid registers with registered in_ready.
- RESET_DATA, 0, value loaded into the payload registers on reset.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all held beats and any beat offered this cycle.
- in_valid  input  1  upstream stage offers a beat.
- in_ready  output  1  this stage accepts a beat this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  downstream payload is valid.
- out_ready  input  1  downstream consumes the beat (0 = stall).
- out_data  output  DATA_W  downstream payload, always driven from the main register.
- occupancy  output  2  beats held: 0, 1 or 2 (2 only when SKID=1).

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- push = in_valid & in_ready. pop = out_valid & out_ready.
- States: EMPTY (occ 0), ONE (main full, occ 1), TWO (main + skid full, occ 2; SKID=1 only).
- out_valid = (state != EMPTY). Latency: a beat accepted at edge N appears on out_data/out_valid after edge N.
- Reset:
  - state goes to EMPTY; out_valid=0; occupancy=0.
  - Main and skid data go to RESET_DATA.
  - in_ready is 1 after reset in both modes.
  - Reset overrides flush and handshakes.
- Flush (rst=0):
  - Next state is EMPTY regardless of push/pop.
  - A beat offered the same cycle is dropped.
  - A pop in the flush cycle still counts as consumed downstream.
  - Data registers keep their contents; the bench checks valid only.
- in_ready:
  - SKID=0: in_ready = ~out_valid | out_ready (combinational path from out_ready).
  - SKID=1: in_ready = (state != TWO), from registered state only, with no path from out_ready.
- Transitions (no flush):
  - EMPTY: push -> ONE, main <= in_data.
  - ONE with push & pop -> ONE, main <= in_data.
  - ONE with push & ~pop -> TWO, skid <= in_data (SKID=1). This case cannot occur in SKID=0, because in_ready=0 there.
  - ONE with ~push & pop -> EMPTY.
  - ONE with neither -> ONE, main held (stall).
  - TWO with pop -> ONE, main <= skid. No push is possible, since in_ready=0.
  - TWO without pop -> TWO, all held.
- Ordering: beats leave strictly in acceptance order. No beat is duplicated or lost except by flush.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid stay stable.
- Protocol: in_valid may drop without acceptance; this stage makes no assumption on upstream stability.
- occupancy is a direct encoding of state.
- Illegal state encoding (3) recovers to EMPTY on the next edge.

Decomposition:
- pipe_pkg holds:
  - State typedef: ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
  - Shared payload-width constants for each stage bundle (IF_ID_W, ID_EX_W, EX_MEM_W, MEM_WB_W).
- No sub-module. Stage-specific wrappers (pack/unpack of control fields into in_data) live outside this block.

Test Plan:
- Reset then idle: assert rst 1 cycle with in_valid=1, in_data=32'hDEAD -> out_valid=0, occupancy=0, out_data=RESET_DATA, in_ready=1 on the following cycle.
- Streaming: out_ready=1, push 32'h1, 32'h2, 32'h3 on consecutive cycles -> out_data shows 1, 2, 3 one cycle later each; occupancy stays 1; no bubbles.
- Stall and skid (SKID=1): out_ready=0 and push 32'hA, 32'hB -> occupancy=2, in_ready=0, out_data=A held. Then raise out_ready -> A popped, then B, then occupancy=0.
- Stall (SKID=0): out_ready=0 with main holding 32'hA and in_valid=1 -> in_ready=0 same cycle; A held stable for 5 cycles; no beat lost.
- Flush: occupancy=2 (A, B) and flush=1 with in_valid=1, in_data=32'hC -> next cycle out_valid=0, occupancy=0; C never appears at the output.
- Simultaneous events: in state ONE with push 32'h5 and pop of 32'h4 in the same cycle -> state ONE, out_data=5; with flush also asserted -> EMPTY. Reset asserted mid-TWO -> EMPTY, and data registers hold RESET_DATA.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: state encoding and
// the payload widths of each inter-stage bundle.
package pipe_pkg;

  typedef logic [1:0] pipe_state_t;

  localparam pipe_state_t ST_EMPTY = 2'd0;
  localparam pipe_state_t ST_ONE   = 2'd1;
  localparam pipe_state_t ST_TWO   = 2'd2;

  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 128;
  localparam int EX_MEM_W = 80;
  localparam int MEM_WB_W = 72;

endpackage

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with stall, flush and optional
// 2-entry skid buffer (registered in_ready when SKID != 0).
//
// state    | meaning
// ---------+------------------------------------------------
// ST_EMPTY | no beat held, out_valid = 0
// ST_ONE   | main register holds the head beat
// ST_TWO   | main holds head, skid holds next (SKID != 0)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                SKID       = 1,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              push, pop;
  logic              main_load, main_from_skid, skid_load;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

  // Skid mode breaks the out_ready -> in_ready combinational path.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = (state_q != ST_TWO);
    end else begin : g_noskid
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d   = ST_ONE;
          main_load = 1'b1;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_load = 1'b1;
        end else if (push && (SKID != 0)) begin
          state_d   = ST_TWO;
          skid_load = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (SKID == 0) begin
          state_d = ST_EMPTY;
        end else if (pop) begin
          state_d        = ST_ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush empties the stage but leaves payload registers untouched.
    if (flush) begin
      state_d        = ST_EMPTY;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_DATA;
      skid_q  <= RESET_DATA;
    end else begin
      state_q <= state_d;
      if (main_load) begin
        main_q <= in_data;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (skid_load) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: drives SKID=0 and SKID=1 instances with identical
// stimulus and compares both against per-instance FIFO queue models.
module tb_pipe_stage_reg;

  localparam logic [31:0] RST_VAL = 32'h0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        rdy[2];
  logic        ov[2];
  logic [31:0] od[2];
  logic [1:0]  occ[2];

  int n_checks = 0;
  int n_fail   = 0;

  // Index 0 models SKID=0 (capacity 1), index 1 models SKID=1 (capacity 2).
  logic [31:0] mq[2][$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .SKID(0), .RESET_DATA(RST_VAL)) u_s0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .occupancy(occ[0])
  );

  pipe_stage_reg #(.DATA_W(32), .SKID(1), .RESET_DATA(RST_VAL)) u_s1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .occupancy(occ[1])
  );

  function automatic bit m_rdy(int k);
    if (k == 1) return mq[1].size() < 2;
    return (mq[0].size() == 0) || (out_ready == 1'b1);
  endfunction

  task automatic step();
    bit p_push[2];
    bit p_pop[2];
    for (int k = 0; k < 2; k++) begin
      p_pop[k]  = (mq[k].size() != 0) && out_ready;
      p_push[k] = in_valid && m_rdy(k);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mq[k].delete();
      end else begin
        if (p_pop[k]) void'(mq[k].pop_front());
        if (flush) mq[k].delete();
        else if (p_push[k]) mq[k].push_back(in_data);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b0;
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (ov[k] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b want 0", k, ov[k]); end
      n_checks++;
      if (occ[k] !== 2'd0) begin n_fail++; $display("FAIL reset_occ[%0d]: got %0d want 0", k, occ[k]); end
      n_checks++;
      if (od[k] !== RST_VAL) begin n_fail++; $display("FAIL reset_data[%0d]: got %h want %h", k, od[k], RST_VAL); end
      n_checks++;
      if (rdy[k] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b want 1", k, rdy[k]); end
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = i;
      step();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (ov[k] !== 1'b1 || od[k] !== i || occ[k] !== 2'd1) begin
          n_fail++;
          $display("FAIL stream[%0d] beat %0d: got v=%b d=%h occ=%0d want v=1 d=%h occ=1", k, i, ov[k], od[k], occ[k], i);
        end
      end
    end
    in_valid = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (ov[k] !== 1'b0) begin n_fail++; $display("FAIL stream_drain[%0d]: got v=%b want 0", k, ov[k]); end
    end
  endtask

  task automatic test_stall_skid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    #1;
    n_checks++;
    if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL stall_ready_s0: got %b want 0", rdy[0]); end
    step();
    n_checks++;
    if (occ[1] !== 2'd2 || rdy[1] !== 1'b0 || od[1] !== 32'hA) begin
      n_fail++;
      $display("FAIL skid_full: got occ=%0d rdy=%b d=%h want occ=2 rdy=0 d=a", occ[1], rdy[1], od[1]);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (ov[k] !== 1'b1 || od[k] !== 32'hA) begin
          n_fail++;
          $display("FAIL stall_hold[%0d] cyc %0d: got v=%b d=%h want v=1 d=a", k, c, ov[k], od[k]);
        end
      end
    end
    // Upstream keeps offering B while the stall releases.
    out_ready = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (od[k] !== 32'hB || occ[k] !== 2'd1) begin
        n_fail++;
        $display("FAIL release[%0d]: got d=%h occ=%0d want d=b occ=1", k, od[k], occ[k]);
      end
    end
    in_valid = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (occ[k] !== 2'd0 || ov[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL release_empty[%0d]: got occ=%0d v=%b want 0 0", k, occ[k], ov[k]);
      end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    flush = 1'b1; in_data = 32'hC;
    step();
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (ov[k] !== 1'b0 || occ[k] !== 2'd0) begin
        n_fail++;
        $display("FAIL flush[%0d]: got v=%b occ=%0d want 0 0", k, ov[k], occ[k]);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (ov[k] !== 1'b0) begin n_fail++; $display("FAIL flush_leak[%0d]: got v=%b d=%h want v=0", k, ov[k], od[k]); end
      end
    end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h4;
    step();
    in_data = 32'h5; out_ready = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (occ[k] !== 2'd1 || od[k] !== 32'h5) begin
        n_fail++;
        $display("FAIL push_pop[%0d]: got occ=%0d d=%h want occ=1 d=5", k, occ[k], od[k]);
      end
    end
    in_data = 32'h6; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (occ[k] !== 2'd0 || ov[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL push_pop_flush[%0d]: got occ=%0d v=%b want 0 0", k, occ[k], ov[k]);
      end
    end
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h7;
    step();
    in_data = 32'h8;
    step();
    n_checks++;
    if (occ[1] !== 2'd2) begin n_fail++; $display("FAIL pre_reset_two: got occ=%0d want 2", occ[1]); end
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (occ[k] !== 2'd0 || ov[k] !== 1'b0 || od[k] !== RST_VAL) begin
        n_fail++;
        $display("FAIL mid_reset[%0d]: got occ=%0d v=%b d=%h want 0 0 %h", k, occ[k], ov[k], od[k], RST_VAL);
      end
    end
    n_checks++;
    if (u_s1.skid_q !== RST_VAL) begin n_fail++; $display("FAIL mid_reset_skid: got %h want %h", u_s1.skid_q, RST_VAL); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = (c < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (rdy[k] !== m_rdy(k)) begin
          n_fail++;
          $display("FAIL rand_ready[%0d] cyc %0d: got %b want %b", k, c, rdy[k], m_rdy(k));
        end
      end
      step();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (ov[k] !== (mq[k].size() != 0) || occ[k] !== 2'(mq[k].size())) begin
          n_fail++;
          $display("FAIL rand_state[%0d] cyc %0d: got v=%b occ=%0d want occ=%0d", k, c, ov[k], occ[k], mq[k].size());
        end
        if (mq[k].size() != 0) begin
          n_checks++;
          if (od[k] !== mq[k][0]) begin
            n_fail++;
            $display("FAIL rand_data[%0d] cyc %0d: got %h want %h", k, c, od[k], mq[k][0]);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_streaming();
    test_stall_skid();
    test_flush();
    test_simultaneous();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
